scs8hd_dbnc_1: RTL and testbench

- Single-bit synchronizing glitch filter (debounce) cell.
- Sits directly upstream of the scs8hd_buf_1 output buffer; its X drives the buffer's A pin.
- Samples the asynchronous input A through a 2-flop synchronizer.
- X changes only after the synchronized input has held a new value for STABLE_CNT consecutive clock edges.
- Flags filter activity and produces a one-cycle edge strobe.

---
 rtl/scs8hd_dbnc_1.sv | 111 +++++++++++
 tb/tb_scs8hd_dbnc_1.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/scs8hd_dbnc_1.sv
// Synchronizing debounce cell: 2-flop sync, then STABLE_CNT-edge qualify.
// Optional power pins via SCS8HD_PG_PIN_EN (vpwr, vgnd, vpb, vnb).
module scs8hd_dbnc_1 #(
    parameter int   STABLE_CNT = 4,
    parameter int   CNT_W      = 3,
    parameter logic RESET_VAL  = 1'b0
) (
    input  logic CLK,
    input  logic RESETB,
    input  logic A,
    output logic X,
    output logic BUSY,
    output logic EDGE
`ifdef SCS8HD_PG_PIN_EN
    ,
    input  logic vpwr,
    input  logic vgnd,
    input  logic vpb,
    input  logic vnb
`endif
);

`ifndef SCS8HD_PG_PIN_EN
    supply1 vpwr;
    supply1 vpb;
    supply0 vgnd;
    supply0 vnb;
`endif

    if (STABLE_CNT < 1 || STABLE_CNT > (1 << CNT_W)) begin : g_bad_cnt
        $error("scs8hd_dbnc_1: STABLE_CNT out of range 1..2**CNT_W");
    end

    typedef enum logic {
        IDLE,
        QUAL
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1;
    logic             sync2;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             x_q, x_d;
    logic             edge_q, edge_d;
    logic             pwr_ok;
    logic             unused_pg;

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            sync1   <= RESET_VAL;
            sync2   <= RESET_VAL;
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= RESET_VAL;
            edge_q  <= 1'b0;
        end else begin
            sync1   <= A;
            sync2   <= sync1;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            edge_q  <= edge_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        edge_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (sync2 != x_q) begin
                    if (STABLE_CNT == 1) begin
                        x_d    = ~x_q;
                        edge_d = 1'b1;
                    end else begin
                        cnt_d   = CNT_ONE;
                        state_d = QUAL;
                    end
                end
            end
            QUAL: begin
                if (sync2 == x_q) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    x_d     = ~x_q;
                    edge_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    // Body-bias pins carry no logic function
    assign unused_pg = vpb ^ vnb;
    assign pwr_ok    = (vpwr === 1'b1) && (vgnd === 1'b0);

    assign X    = pwr_ok ? x_q : 1'bx;
    assign BUSY = pwr_ok ? (state_q == QUAL) : 1'bx;
    assign EDGE = pwr_ok ? edge_q : 1'bx;

endmodule

// File: tb/tb_scs8hd_dbnc_1.sv
// Bench for scs8hd_dbnc_1: STABLE_CNT=4 and STABLE_CNT=1 instances
// against a run-length reference model, directed plus random stimulus.
module tb_scs8hd_dbnc_1;

    logic CLK = 1'b0;
    logic RESETB;
    logic A;
    logic x4, b4, e4;
    logic x1, b1, e1;
`ifdef SCS8HD_PG_PIN_EN
    logic vpwr = 1'b1;
    logic vgnd = 1'b0;
    logic vpb  = 1'b1;
    logic vnb  = 1'b0;
`endif

    always #5 CLK = ~CLK;

    scs8hd_dbnc_1 #(.STABLE_CNT(4), .CNT_W(3), .RESET_VAL(1'b0)) u_dut4 (
        .CLK(CLK), .RESETB(RESETB), .A(A),
        .X(x4), .BUSY(b4), .EDGE(e4)
`ifdef SCS8HD_PG_PIN_EN
        , .vpwr(vpwr), .vgnd(vgnd), .vpb(vpb), .vnb(vnb)
`endif
    );

    scs8hd_dbnc_1 #(.STABLE_CNT(1), .CNT_W(3), .RESET_VAL(1'b0)) u_dut1 (
        .CLK(CLK), .RESETB(RESETB), .A(A),
        .X(x1), .BUSY(b1), .EDGE(e1)
`ifdef SCS8HD_PG_PIN_EN
        , .vpwr(1'b1), .vgnd(1'b0), .vpb(1'b1), .vnb(1'b0)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference: A seen by the filter is A from two edges earlier;
    // X flips once it has disagreed for stab consecutive edges.
    int stab [2] = '{4, 1};
    bit ms1  [2];
    bit ms2  [2];
    bit mx   [2];
    bit me   [2];
    int run  [2];

    task automatic check(string tag, logic obs, logic exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ms1[i] = 1'b0;
            ms2[i] = 1'b0;
            mx[i]  = 1'b0;
            me[i]  = 1'b0;
            run[i] = 0;
        end
    endtask

    task automatic model_edge(logic a);
        for (int i = 0; i < 2; i++) begin
            bit seen;
            seen   = ms2[i];
            ms2[i] = ms1[i];
            ms1[i] = a;
            me[i]  = 1'b0;
            if (seen != mx[i]) begin
                run[i]++;
                if (run[i] == stab[i]) begin
                    mx[i]  = ~mx[i];
                    me[i]  = 1'b1;
                    run[i] = 0;
                end
            end else begin
                run[i] = 0;
            end
        end
    endtask

    task automatic check_all(string tag);
        check({tag, ".x4"}, x4, mx[0]);
        check({tag, ".busy4"}, b4, run[0] > 0);
        check({tag, ".edge4"}, e4, me[0]);
        check({tag, ".x1"}, x1, mx[1]);
        check({tag, ".busy1"}, b1, run[1] > 0);
        check({tag, ".edge1"}, e1, me[1]);
    endtask

    // Called at a negedge: drive A, take one rising edge, check at negedge
    task automatic cycle(logic a_next, string tag);
        A = a_next;
        @(posedge CLK);
        model_edge(A);
        @(negedge CLK);
        check_all(tag);
    endtask

    task automatic async_reset(string tag);
        #2;
        RESETB = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        @(negedge CLK);
        RESETB = 1'b1;
    endtask

    initial begin
        RESETB = 1'b0;
        A      = 1'b1;
        model_reset();
        #1;
        check_all("rst");
        check("rst.x4_const", x4, 1'b0);
        @(negedge CLK);
        RESETB = 1'b1;
        for (int k = 0; k < 3; k++) cycle(1'b0, "idle0");
        check("idle0.x4_const", x4, 1'b0);

        for (int k = 1; k <= 8; k++) begin
            cycle(1'b1, "rise");
            if (k == 2) check("rise.busy_e2", b4, 1'b0);
            if (k == 3) check("rise.busy_e3", b4, 1'b1);
            if (k == 3) check("rise.x1_e3", x1, 1'b1);
            if (k == 5) check("rise.x_e5", x4, 1'b0);
            if (k == 6) check("rise.x_e6", x4, 1'b1);
            if (k == 6) check("rise.edge_e6", e4, 1'b1);
            if (k == 6) check("rise.busy_e6", b4, 1'b0);
            if (k == 7) check("rise.edge_e7", e4, 1'b0);
        end

        for (int k = 1; k <= 10; k++) begin
            cycle(1'b0, "fall");
            if (k == 2) check("fall.x1_e2", x1, 1'b1);
            if (k == 3) check("fall.x1_e3", x1, 1'b0);
            if (k == 3) check("fall.edge1_e3", e1, 1'b1);
            if (k == 4) check("fall.edge1_e4", e1, 1'b0);
        end

        for (int k = 1; k <= 3; k++) cycle(1'b1, "glitch_hi");
        check("glitch.busy", b4, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            cycle(1'b0, "glitch_lo");
            check("glitch.x4", x4, 1'b0);
            check("glitch.edge4", e4, 1'b0);
        end

        for (int k = 1; k <= 4; k++) cycle(1'b1, "midq");
        check("midq.busy_pre", b4, 1'b1);
        async_reset("midq_rst");
        check("midq.busy_rst", b4, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            cycle(1'b1, "midq_rel");
            if (k == 5) check("midq.x_e5", x4, 1'b0);
            if (k == 6) check("midq.x_e6", x4, 1'b1);
        end

        for (int n = 0; n < 300; n++) begin
            logic v;
            int   len;
            v   = 1'($urandom);
            len = int'($urandom_range(1, 7));
            if ($urandom_range(0, 19) == 0) async_reset("rnd_rst");
            for (int k = 0; k < len; k++) cycle(v, "rnd");
        end

`ifdef SCS8HD_PG_PIN_EN
        vpwr = 1'b0;
        #1;
        check("pg.x", x4, 1'bx);
        check("pg.busy", b4, 1'bx);
        check("pg.edge", e4, 1'bx);
        vpwr = 1'b1;
        vgnd = 1'b0;
        #1;
        check("pg.x_back", x4, mx[0]);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
